// File: rtl/gate_sensor_ctrl_if.sv
// rtl/gate_sensor_ctrl_if.sv - sensor levels in, vehicle events and gate controls out
interface gate_sensor_ctrl_if;
  logic car_in_raw;
  logic car_out_raw;
  logic parking_full;
  logic car_in;
  logic car_out;
  logic gate_in_open;
  logic gate_out_open;
  logic entry_denied;

  modport slave (
    input  car_in_raw, car_out_raw, parking_full,
    output car_in, car_out, gate_in_open, gate_out_open, entry_denied
  );

  modport master (
    output car_in_raw, car_out_raw, parking_full,
    input  car_in, car_out, gate_in_open, gate_out_open, entry_denied
  );
endinterface

// File: rtl/gate_sensor_ctrl.sv
// rtl/gate_sensor_ctrl.sv - per-lane debounce, gate window and event arbitration for the parking counter

// One lane: synchroniser, debounce FSM and gate-open window.
// o_accept is a one-cycle strobe on the edge a press is accepted; i_block
// (sampled on that same edge) decides whether the gate opens or the lane
// just waits for release.
module gate_sensor_lane #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GATE_CYCLES     = 8,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_block,
  output logic o_accept,
  output logic o_gate
);
  typedef enum logic [1:0] {IDLE, ARMING, OPEN, RELEASE} state_t;

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] GATE_MAX = CNT_W'(GATE_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_gate, w_gate_nxt;
  logic [1:0]       r_sync;
  logic             w_level;

  assign w_level = r_sync[1];
  assign o_gate  = r_gate;

  // Two-flop synchroniser for the asynchronous sensor level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= 2'b00;
    else      r_sync <= {r_sync[0], i_raw};
  end

  // Lane state, shared debounce/gate counter and registered gate output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gate  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gate  <= w_gate_nxt;
    end
  end

  // Next state: debounce in ARMING, timed window in OPEN, wait for low in RELEASE
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gate_nxt  = r_gate;
    o_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_level) begin
          w_state_nxt = ARMING;
          w_cnt_nxt   = ONE;
        end
      end
      ARMING: begin
        if (!w_level) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_MAX) begin
          o_accept = 1'b1;
          if (i_block) begin
            w_state_nxt = RELEASE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = OPEN;
            w_cnt_nxt   = ONE;
            w_gate_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      OPEN: begin
        if (r_cnt == GATE_MAX) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = '0;
          w_gate_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      RELEASE: begin
        if (!w_level) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_gate_nxt  = 1'b0;
      end
    endcase
  end
endmodule

// Top: two lanes plus the car_out-first arbiter feeding park_system.
module gate_sensor_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GATE_CYCLES     = 8,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  gate_sensor_ctrl_if.slave  bus
);
  logic w_in_acc, w_out_acc, w_gate_in, w_gate_out, w_in_req;
  logic r_car_in, r_car_out, r_entry_denied, r_pend;

  gate_sensor_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .GATE_CYCLES(GATE_CYCLES), .CNT_W(CNT_W)
  ) u_entry (
    .clk(clk), .rst(rst), .i_raw(bus.car_in_raw), .i_block(bus.parking_full),
    .o_accept(w_in_acc), .o_gate(w_gate_in)
  );

  gate_sensor_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .GATE_CYCLES(GATE_CYCLES), .CNT_W(CNT_W)
  ) u_exit (
    .clk(clk), .rst(rst), .i_raw(bus.car_out_raw), .i_block(1'b0),
    .o_accept(w_out_acc), .o_gate(w_gate_out)
  );

  // An entry request is either a fresh non-full accept or one deferred last cycle
  assign w_in_req = (w_in_acc & ~bus.parking_full) | r_pend;

  // Registered event pulses; car_out wins a tie and car_in waits one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_car_in       <= 1'b0;
      r_car_out      <= 1'b0;
      r_entry_denied <= 1'b0;
      r_pend         <= 1'b0;
    end else begin
      r_car_out      <= w_out_acc;
      r_car_in       <= w_in_req & ~w_out_acc;
      r_pend         <= w_in_req & w_out_acc;
      r_entry_denied <= w_in_acc & bus.parking_full;
    end
  end

  assign bus.car_in        = r_car_in;
  assign bus.car_out       = r_car_out;
  assign bus.entry_denied  = r_entry_denied;
  assign bus.gate_in_open  = w_gate_in;
  assign bus.gate_out_open = w_gate_out;
endmodule

// File: tb/tb_gate_sensor_ctrl.sv
// tb/tb_gate_sensor_ctrl.sv - scoreboard bench for gate_sensor_ctrl
module tb_gate_sensor_ctrl;
  localparam int DEB  = 4;
  localparam int GATE = 3;
  localparam int LAT  = DEB + 3;  // raw set after edge c -> pulse at edge c+LAT

  localparam int K_IN   = 0;
  localparam int K_OUT  = 1;
  localparam int K_DENY = 2;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   gi_from = 0, gi_to = 0, go_from = 0, go_to = 0;
  ev_t  sb[$];

  gate_sensor_ctrl_if bus ();

  gate_sensor_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .GATE_CYCLES(GATE), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, cyc);
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      chk($sformatf("unexpected_pulse_kind%0d", kind), 1, 0);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_edge", cyc, e.at);
    end
  endtask

  task automatic observe();
    chk("in_out_overlap", int'(bus.car_in & bus.car_out), 0);
    chk("gate_in_open", int'(bus.gate_in_open), int'(cyc >= gi_from && cyc < gi_to));
    chk("gate_out_open", int'(bus.gate_out_open), int'(cyc >= go_from && cyc < go_to));
    if (bus.car_out)      pop_cmp(K_OUT);
    if (bus.car_in)       pop_cmp(K_IN);
    if (bus.entry_denied) pop_cmp(K_DENY);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      observe();
    end
  endtask

  initial begin
    int c;
    bus.car_in_raw   = 1'b1;
    bus.car_out_raw  = 1'b1;
    bus.parking_full = 1'b0;

    // reset held with both sensors high
    run(3);
    chk("rst_car_in", int'(bus.car_in), 0);
    chk("rst_car_out", int'(bus.car_out), 0);
    chk("rst_entry_denied", int'(bus.entry_denied), 0);
    chk("rst_gate_in", int'(bus.gate_in_open), 0);
    chk("rst_gate_out", int'(bus.gate_out_open), 0);
    bus.car_out_raw = 1'b0;
    rst = 1'b1;
    c = cyc;
    push(K_IN, c + LAT);
    gi_from = c + LAT; gi_to = c + LAT + GATE;
    run(12);
    bus.car_in_raw = 1'b0;
    run(4);

    // bounce shorter than debounce, then a real hold
    bus.car_in_raw = 1'b1; run(1);
    bus.car_in_raw = 1'b1; run(1);
    bus.car_in_raw = 1'b0; run(1);
    bus.car_in_raw = 1'b1; run(1);
    bus.car_in_raw = 1'b1; run(1);
    bus.car_in_raw = 1'b1; run(1);
    bus.car_in_raw = 1'b0; run(1);
    bus.car_in_raw = 1'b1;
    c = cyc;
    push(K_IN, c + LAT);
    gi_from = c + LAT; gi_to = c + LAT + GATE;
    run(12);
    bus.car_in_raw = 1'b0;
    run(4);

    // full garage: denial, no repeat while held, denial again on re-press
    bus.parking_full = 1'b1;
    bus.car_in_raw   = 1'b1;
    c = cyc;
    push(K_DENY, c + LAT);
    run(20);
    bus.car_in_raw = 1'b0;
    run(4);
    bus.car_in_raw = 1'b1;
    c = cyc;
    push(K_DENY, c + LAT);
    run(10);
    bus.car_in_raw   = 1'b0;
    bus.parking_full = 1'b0;
    run(4);

    // simultaneous entry and exit
    bus.car_in_raw  = 1'b1;
    bus.car_out_raw = 1'b1;
    c = cyc;
    push(K_OUT, c + LAT);
    push(K_IN, c + LAT + 1);
    gi_from = c + LAT; gi_to = c + LAT + GATE;
    go_from = c + LAT; go_to = c + LAT + GATE;
    run(12);
    bus.car_in_raw  = 1'b0;
    bus.car_out_raw = 1'b0;
    run(4);

    // long hold on exit, then a one-cycle low and a new press
    bus.car_out_raw = 1'b1;
    c = cyc;
    push(K_OUT, c + LAT);
    go_from = c + LAT; go_to = c + LAT + GATE;
    run(50);
    bus.car_out_raw = 1'b0;
    run(1);
    bus.car_out_raw = 1'b1;
    c = cyc;
    push(K_OUT, c + LAT);
    go_from = c + LAT; go_to = c + LAT + GATE;
    run(12);
    bus.car_out_raw = 1'b0;
    run(4);

    // reset asserted on the second gate cycle
    bus.car_out_raw = 1'b1;
    c = cyc;
    push(K_OUT, c + LAT);
    go_from = c + LAT; go_to = c + LAT + GATE;
    run(LAT + 1);
    chk("gate_out_before_rst", int'(bus.gate_out_open), 1);
    rst = 1'b0;
    bus.car_out_raw = 1'b0;
    #1;
    chk("gate_out_async_rst", int'(bus.gate_out_open), 0);
    go_to = cyc;
    run(2);
    rst = 1'b1;
    run(12);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
